// File: rtl/mig_model_pkg.sv
// mig_model_pkg: command codes, FIFO geometry and byte-merge helper for the MIG behavioural model
package mig_model_pkg;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PW = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH + 1);
    localparam int DATA_W = 128;
    localparam int MASK_W = DATA_W / 8;

    // A set mask bit keeps the old byte
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w, new_w,
                                                      input logic [MASK_W-1:0] keep);
        logic [DATA_W-1:0] r;
        for (int b = 0; b < MASK_W; b++) r[b*8+:8] = keep[b] ? old_w[b*8+:8] : new_w[b*8+:8];
        return r;
    endfunction
endpackage

// File: rtl/mig_7series_0_if.sv
// mig_7series_0_if: user-side application bus of the MIG model
interface mig_7series_0_if;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid, app_rd_data_end;
    logic         app_sr_req, app_ref_req, app_zq_req;
    logic         app_sr_active, app_ref_ack, app_zq_ack;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
               app_sr_req, app_ref_req, app_zq_req,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               app_sr_active, app_ref_ack, app_zq_ack
    );
    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
               app_sr_req, app_ref_req, app_zq_req,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
               app_sr_active, app_ref_ack, app_zq_ack
    );
endinterface

// File: rtl/mig_7series_0_fifo.sv
// mig_sync_fifo: 4-entry synchronous FIFO with occupancy count, active-low sync reset
module mig_sync_fifo import mig_model_pkg::*; #(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [W-1:0]       din,
    output logic [W-1:0]       dout,
    output logic [FIFO_CW-1:0] count
);
    logic [W-1:0]       mem [FIFO_DEPTH];
    logic [FIFO_PW-1:0] wp, rp;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
        wp <= !rst ? '0 : wp + FIFO_PW'(push);
        rp <= !rst ? '0 : rp + FIFO_PW'(pop);
        count <= !rst ? '0 : count + FIFO_CW'(push) - FIFO_CW'(pop);
    end

    assign dout = mem[rp];
endmodule

// File: rtl/mig_7series_0.sv
// mig_7series_0: behavioural stand-in for a DDR2 MIG core with in-order command/data FIFOs,
// a 128-bit backing store and a fixed-latency read pipeline
module mig_7series_0 import mig_model_pkg::*; #(
    parameter int MEM_AW     = 10,
    parameter int CAL_CYCLES = 16,
    parameter int RD_LAT     = 8
) (
    input  logic        sys_clk_i,
    input  logic        clk_ref_i,
    input  logic        rst,
    output logic        ui_clk,
    output logic        ui_clk_sync_rst,
    output logic        init_calib_complete,
    mig_7series_0_if.slave app,
    inout  wire  [15:0] ddr2_dq,
    inout  wire  [1:0]  ddr2_dqs_p,
    inout  wire  [1:0]  ddr2_dqs_n,
    output logic [12:0] ddr2_addr,
    output logic [2:0]  ddr2_ba,
    output logic        ddr2_ras_n, ddr2_cas_n, ddr2_we_n,
    output logic        ddr2_ck_p, ddr2_ck_n, ddr2_cke, ddr2_cs_n, ddr2_odt,
    output logic [1:0]  ddr2_dm
);
    localparam int CW = $clog2(CAL_CYCLES + 1);
    localparam int QW = 3 + MEM_AW;

    logic [CW-1:0]            cal_cnt;
    logic [FIFO_CW-1:0]       cmd_cnt, wdf_cnt;
    logic [QW-1:0]            cmd_head;
    logic [DATA_W+MASK_W-1:0] wdf_head;
    logic [2:0]               head_cmd;
    logic [MEM_AW-1:0]        head_idx;
    logic                     cmd_push, wdf_push, cmd_pop, do_wr, do_rd, unused;
    logic [DATA_W-1:0]        mem [2**MEM_AW] = '{default: '0};
    logic [RD_LAT-1:0]        rd_v;
    logic [DATA_W-1:0]        rd_d [RD_LAT];

    assign ui_clk = sys_clk_i;
    assign ui_clk_sync_rst = !rst;

    always_ff @(posedge ui_clk)
        cal_cnt <= !rst ? '0 : init_calib_complete ? cal_cnt : cal_cnt + 1'b1;

    assign init_calib_complete = cal_cnt == CW'(CAL_CYCLES);
    assign app.app_rdy = init_calib_complete && cmd_cnt < FIFO_CW'(FIFO_DEPTH);
    assign app.app_wdf_rdy = init_calib_complete && wdf_cnt < FIFO_CW'(FIFO_DEPTH);
    assign cmd_push = app.app_en && app.app_rdy;
    assign wdf_push = app.app_wdf_wren && app.app_wdf_rdy;

    mig_sync_fifo #(.W(QW)) u_cmd_fifo (
        .clk(ui_clk), .rst(rst), .push(cmd_push), .pop(cmd_pop),
        .din({app.app_cmd, app.app_addr[MEM_AW+2:3]}), .dout(cmd_head), .count(cmd_cnt)
    );

    mig_sync_fifo #(.W(DATA_W + MASK_W)) u_wdf_fifo (
        .clk(ui_clk), .rst(rst), .push(wdf_push), .pop(do_wr),
        .din({app.app_wdf_data, app.app_wdf_mask}), .dout(wdf_head), .count(wdf_cnt)
    );

    // A write at the head stalls everything behind it until its data beat is present
    assign {head_cmd, head_idx} = cmd_head;
    assign cmd_pop = rst && cmd_cnt != '0 && (head_cmd != CMD_WR || wdf_cnt != '0);
    assign do_wr = cmd_pop && head_cmd == CMD_WR;
    assign do_rd = cmd_pop && head_cmd == CMD_RD;

    always_ff @(posedge ui_clk)
        if (do_wr) mem[head_idx] <= merge_bytes(mem[head_idx], wdf_head[DATA_W+MASK_W-1:MASK_W],
                                                wdf_head[MASK_W-1:0]);

    always_ff @(posedge ui_clk) begin
        rd_v <= !rst ? '0 : {rd_v[RD_LAT-2:0], do_rd};
        rd_d[0] <= mem[head_idx];
        for (int i = 1; i < RD_LAT; i++) rd_d[i] <= rd_d[i-1];
        app.app_sr_active <= rst && app.app_sr_req;
        app.app_ref_ack <= rst && app.app_ref_req;
        app.app_zq_ack <= rst && app.app_zq_req;
    end

    assign app.app_rd_data_valid = rd_v[RD_LAT-1];
    assign app.app_rd_data_end = rd_v[RD_LAT-1];
    assign app.app_rd_data = rd_v[RD_LAT-1] ? rd_d[RD_LAT-1] : '0;

    assign ddr2_dq = 16'bz;
    assign ddr2_dqs_p = 2'bz;
    assign ddr2_dqs_n = 2'bz;
    assign ddr2_addr = '0;
    assign ddr2_ba = '0;
    assign {ddr2_ras_n, ddr2_cas_n, ddr2_we_n, ddr2_cs_n} = 4'hF;
    assign {ddr2_ck_p, ddr2_ck_n, ddr2_odt} = 3'b000;
    assign ddr2_dm = '0;
    assign ddr2_cke = init_calib_complete;

    assign unused = ^{clk_ref_i, app.app_wdf_end, app.app_addr[26:MEM_AW+3], app.app_addr[2:0],
                      ddr2_dq, ddr2_dqs_p, ddr2_dqs_n};
endmodule

// File: tb/tb_mig_7series_0.sv
// tb_mig_7series_0: directed self-checking bench for the MIG behavioural model
module tb_mig_7series_0;
    logic        sys_clk_i = 0, clk_ref_i = 0, rst = 0;
    logic        ui_clk, ui_clk_sync_rst, init_calib_complete;
    wire  [15:0] ddr2_dq;
    wire  [1:0]  ddr2_dqs_p, ddr2_dqs_n;
    logic [12:0] ddr2_addr;
    logic [2:0]  ddr2_ba;
    logic        ddr2_ras_n, ddr2_cas_n, ddr2_we_n, ddr2_ck_p, ddr2_ck_n, ddr2_cke, ddr2_cs_n, ddr2_odt;
    logic [1:0]  ddr2_dm;
    int          checks = 0, failures = 0;

    mig_7series_0_if app();

    mig_7series_0 dut (
        .sys_clk_i(sys_clk_i), .clk_ref_i(clk_ref_i), .rst(rst), .ui_clk(ui_clk),
        .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete), .app(app),
        .ddr2_dq(ddr2_dq), .ddr2_dqs_p(ddr2_dqs_p), .ddr2_dqs_n(ddr2_dqs_n), .ddr2_addr(ddr2_addr),
        .ddr2_ba(ddr2_ba), .ddr2_ras_n(ddr2_ras_n), .ddr2_cas_n(ddr2_cas_n), .ddr2_we_n(ddr2_we_n),
        .ddr2_ck_p(ddr2_ck_p), .ddr2_ck_n(ddr2_ck_n), .ddr2_cke(ddr2_cke), .ddr2_cs_n(ddr2_cs_n),
        .ddr2_odt(ddr2_odt), .ddr2_dm(ddr2_dm)
    );

    always #5 sys_clk_i = ~sys_clk_i;
    always #7 clk_ref_i = ~clk_ref_i;

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [26:0] a, input bit wr,
                         input logic [127:0] d, input logic [15:0] m);
        app.app_en = 1; app.app_cmd = c; app.app_addr = a;
        app.app_wdf_wren = wr; app.app_wdf_end = wr; app.app_wdf_data = d; app.app_wdf_mask = m;
        tick();
        app.app_en = 0; app.app_wdf_wren = 0; app.app_wdf_end = 0;
    endtask

    task automatic beat(input logic [127:0] d, input logic [15:0] m);
        app.app_wdf_wren = 1; app.app_wdf_end = 1; app.app_wdf_data = d; app.app_wdf_mask = m;
        tick();
        app.app_wdf_wren = 0; app.app_wdf_end = 0;
    endtask

    task automatic wait_rd(output logic [127:0] d, output bit found);
        found = 0; d = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (app.app_rd_data_valid) begin
                found = 1; d = app.app_rd_data;
            end
        end
    endtask

    localparam logic [127:0] P0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] P1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin
        logic [127:0] d;
        bit found;
        int seen;
        app.app_en = 0; app.app_cmd = 0; app.app_addr = 0; app.app_wdf_data = 0; app.app_wdf_mask = 0;
        app.app_wdf_wren = 0; app.app_wdf_end = 0;
        app.app_sr_req = 0; app.app_ref_req = 0; app.app_zq_req = 0;
        repeat (3) tick();
        chk("rst_calib", init_calib_complete, 0);
        chk("rst_rdy", {app.app_rdy, app.app_wdf_rdy}, 0);
        chk("rst_sync", ui_clk_sync_rst, 1);
        chk("rst_valid", app.app_rd_data_valid, 0);
        chk("rst_maint", {app.app_sr_active, app.app_ref_ack, app.app_zq_ack}, 0);

        rst = 1;
        repeat (15) tick();
        chk("calib_15", {init_calib_complete, app.app_rdy, app.app_wdf_rdy, ddr2_cke}, 0);
        tick();
        chk("calib_16", {init_calib_complete, app.app_rdy, app.app_wdf_rdy, ddr2_cke}, 4'hF);
        chk("sync_rst_low", ui_clk_sync_rst, 0);
        chk("ddr2_ctl", {ddr2_ras_n, ddr2_cas_n, ddr2_we_n, ddr2_cs_n, ddr2_odt, ddr2_addr}, {4'hF, 14'h0});

        issue(3'b000, 27'h20, 1, P0, 16'h0);
        issue(3'b001, 27'h20, 0, 0, 0);
        repeat (7) tick();
        chk("lat_7", app.app_rd_data_valid, 0);
        tick();
        chk("lat_8_valid", {app.app_rd_data_valid, app.app_rd_data_end}, 2'b11);
        chk("lat_8_data", app.app_rd_data, P0);
        tick();
        chk("lat_9", app.app_rd_data_valid, 0);

        beat(P1, 16'h0);
        repeat (2) tick();
        issue(3'b000, 27'h40, 0, 0, 0);
        issue(3'b001, 27'h40, 0, 0, 0);
        wait_rd(d, found);
        chk("early_found", found, 1);
        chk("early_data", d, P1);

        issue(3'b000, 27'h60, 1, {16{8'hFF}}, 16'h0);
        issue(3'b000, 27'h60, 1, {16{8'h11}}, 16'h00FF);
        issue(3'b001, 27'h60, 0, 0, 0);
        wait_rd(d, found);
        chk("mask_found", found, 1);
        chk("mask_data", d, {{8{8'h11}}, {8{8'hFF}}});

        issue(3'b010, 27'h20, 0, 0, 0);
        issue(3'b001, 27'h200, 0, 0, 0);
        wait_rd(d, found);
        chk("noop_zero_found", found, 1);
        chk("zero_init_data", d, 0);

        app.app_en = 1; app.app_cmd = 3'b000; app.app_addr = 27'h80;
        repeat (3) tick();
        chk("full_3", app.app_rdy, 1);
        tick();
        chk("full_4", app.app_rdy, 0);
        tick();
        chk("full_5", app.app_rdy, 0);
        app.app_en = 0;
        chk("full_wdf_rdy", app.app_wdf_rdy, 1);
        for (int i = 0; i < 4; i++) beat({16{8'hA0 + 8'(i)}}, 16'h0);
        repeat (3) tick();
        chk("drain_rdy", app.app_rdy, 1);
        issue(3'b001, 27'h80, 0, 0, 0);
        wait_rd(d, found);
        chk("drain_data", d, {16{8'hA3}});

        app.app_ref_req = 1; app.app_zq_req = 1; app.app_sr_req = 1;
        tick();
        chk("maint_on", {app.app_sr_active, app.app_ref_ack, app.app_zq_ack}, 3'b111);
        app.app_ref_req = 0; app.app_zq_req = 0;
        tick();
        chk("maint_off", {app.app_sr_active, app.app_ref_ack, app.app_zq_ack}, 3'b100);
        app.app_sr_req = 0;
        tick();
        chk("sr_off", app.app_sr_active, 0);

        issue(3'b001, 27'h20, 0, 0, 0);
        repeat (3) tick();
        rst = 0;
        tick();
        chk("midrst_state", {init_calib_complete, app.app_rdy, app.app_wdf_rdy, ui_clk_sync_rst}, 4'b0001);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (app.app_rd_data_valid) seen++;
        end
        rst = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (app.app_rd_data_valid) seen++;
        end
        chk("midrst_no_valid", 128'(seen), 0);
        chk("recal", init_calib_complete, 1);
        issue(3'b001, 27'h20, 0, 0, 0);
        wait_rd(d, found);
        chk("mem_kept", d, P0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mig_7series_0.md
MIG_7SERIES_0 -- requirements
Module: mig_7series_0

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-low; clock ui_clk.
REQ-002 Parameter MEM_AW, default 10, SHALL set the number of 128-bit words in the backing store (2^MEM_AW).
REQ-003 Parameter CAL_CYCLES, default 16, SHALL set the number of cycles from reset release to calibration complete.
REQ-004 Parameter RD_LAT, default 8, SHALL set the read latency, from command acceptance to valid data.
REQ-005 Ports, as name / direction / width / meaning:
- ui_clk  out  1  user clock; equals sys_clk_i; all state SHALL be clocked on its rising edge
- rst  in  1  synchronous active-low reset
- sys_clk_i, clk_ref_i  in  1 each  system and reference clocks; clk_ref_i is unused
- app_addr  in  27  address in 16-bit units; the word index is app_addr[MEM_AW+2:3]
- app_cmd  in  3  command: 000 = write, 001 = read, all other codes are a no-op
- app_en  in  1  command strobe
- app_rdy  out  1  command accepted when app_en && app_rdy
- app_wdf_data  in  128  write data
- app_wdf_mask  in  16  byte mask; 1 = keep the old byte
- app_wdf_wren, app_wdf_end  in  1 each  write-data strobe and last-beat flag
- app_wdf_rdy  out  1  write data accepted when app_wdf_wren && app_wdf_rdy
- app_rd_data  out  128  read data
- app_rd_data_valid, app_rd_data_end  out  1 each  read-data qualifiers
- app_sr_req, app_ref_req, app_zq_req  in  1 each  maintenance requests
- app_sr_active, app_ref_ack, app_zq_ack  out  1 each  maintenance responses
- ui_clk_sync_rst  out  1  active-high copy of the reset state
- init_calib_complete  out  1  calibration done
- ddr2_dq [15:0], ddr2_dqs_p/n [1:0]  inout  bus pins; always high-Z
- ddr2_addr [12:0], ddr2_ba [2:0], ddr2_ras_n/cas_n/we_n, ddr2_ck_p/n, ddr2_cke, ddr2_cs_n, ddr2_dm [1:0], ddr2_odt  out  DDR2 pins

Function
REQ-006 The calibration counter SHALL count from reset release; init_calib_complete SHALL rise exactly CAL_CYCLES cycles after release and then stay high.
REQ-007 app_rdy SHALL equal init_calib_complete && (command FIFO count < 4).
REQ-008 app_wdf_rdy SHALL equal init_calib_complete && (write-data FIFO count < 4).
REQ-009 Each accepted command SHALL push {cmd, word index} into a 4-entry in-order command FIFO.
REQ-010 Each accepted data beat SHALL push {data, mask} into a 4-entry write-data FIFO; data MAY arrive before, with, or after its command; app_wdf_end is ignored (one beat per burst).
REQ-011 Execution SHALL remove at most one command per cycle from the FIFO head:
- write: executes only when the data FIFO is non-empty; pops both FIFOs and writes the unmasked bytes.
- read: executes unconditionally and enters the read pipeline with the memory word.
- no-op: pops the head only.
REQ-012 The head SHALL block while it is a write with an empty data FIFO (strict ordering, so read-after-write returns the new data).
REQ-013 The read pipeline SHALL be an RD_LAT-stage shift register; app_rd_data_valid and app_rd_data_end SHALL both pulse for 1 cycle per read, in issue order.
REQ-014 Memory SHALL initialise to all zeros at time 0; reset SHALL NOT clear memory contents.
REQ-015 app_ref_ack and app_zq_ack SHALL pulse 1 cycle after their request; app_sr_active SHALL follow app_sr_req registered.
REQ-016 ddr2_cke SHALL equal init_calib_complete, ras_n/cas_n/we_n/cs_n SHALL be 1, and all other DDR2 outputs SHALL be 0.
REQ-017 Simultaneous push and pop on the same FIFO SHALL leave its count unchanged.

Reset
REQ-018 While rst is 0: both FIFOs and the read pipeline SHALL be empty, the calibration counter 0, and every app_* output and init_calib_complete SHALL be 0.
REQ-019 ui_clk_sync_rst SHALL be 1 during reset.
REQ-020 A reset mid-operation SHALL discard pending commands, data, and reads.

Structure
REQ-021 Command encodings and the FIFO depth SHALL live in shared package mig_model_pkg.
REQ-022 A single sub-module, mig_sync_fifo (parameterised width, depth 4), SHALL be instantiated twice.

Verification
REQ-023 Release reset -> init_calib_complete, app_rdy and app_wdf_rdy rise on cycle 16.
REQ-024 Write 0x00..0F at address 0x20, then read 0x20 -> app_rd_data_valid 8 cycles after the read is accepted, with data 0x00..0F and app_rd_data_end=1.
REQ-025 Write data 2 cycles before its command, then read back -> data matches.
REQ-026 Write with mask 16'h00FF over 0xFF..FF, then 0x11..11 -> read gives upper 8 bytes 0x11 and lower 8 bytes 0xFF.
REQ-027 Issue 5 writes with no data -> app_rdy low after 4.
REQ-028 Reset asserted mid-read -> no valid pulse.
